fc: RTL
=======

# fc

Instruction fetch controller: the memory-side responder for the instruction cache's miss requests. It latches a miss address from the instruction cache and reads four bytes over the byte-wide RAM port. It assembles them little-endian into one 32-bit instruction and returns it with a one-cycle `is_commit`/`is_instr` pulse. It sits between the instruction cache and the RAM port, and aborts any in-flight fetch on a ROB exception.

## Interface

Parameters:
- `PcLength`: 31 (from `parameters.v`). Address MSB index.
- `DataLength`: 31 (from `parameters.v`). Instruction MSB index.

Ports:
- `clk`: in, 1. The only clock; everything is on the rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `rdy`: in, 1. Global ready; low freezes the block.
- `addr_from_ic`: in, 32. Miss address; valid while `is_empty_from_ic` is low.
- `is_empty_from_ic`: in, 1. Low = request present. Normally a one-cycle low pulse.
- `is_exception_from_rob`: in, 1. Flush; abort the current fetch.
- `mem_din`: in, 8. RAM read data. Carries the byte addressed in the previous cycle.
- `mem_a`: out, 32. RAM byte address.
- `mem_wr`: out, 1. RAM write enable; constant 0 (read-only block).
- `instr_to_ic`: out, 32. Assembled instruction.
- `is_instr_to_ic`: out, 1. Instruction valid pulse.
- `is_commit_to_ic`: out, 1. Transaction complete pulse; always equal to `is_instr_to_ic`.

## Operation

- States: IDLE, FETCH.
- Registers:
  - `base` (32 bits).
  - `issue_cnt` and `rcv_cnt` (3 bits each, range 0..4).
  - byte buffer (4×8 bits).
- IDLE, edge with `is_empty_from_ic`=0 and no exception:
  - `base` ← `addr_from_ic`; both counters ← 0; go to FETCH.
- FETCH, each cycle with `rdy`=1:
  - `mem_a` = `base + issue_cnt` (modulo 2^32; `base+3` wraps).
  - If a byte was issued last cycle, capture `mem_din` into buffer slot `rcv_cnt`, then increment `rcv_cnt`.
  - `issue_cnt` increments until it reaches 4.
- Completion, edge where the 4th byte is captured:
  - `instr_to_ic` ← {b3,b2,b1,b0}; both pulse outputs ← 1; state ← IDLE.
  - Both pulse outputs clear on the next edge.
- Requests arriving while in FETCH are ignored (the cache never issues while a miss is pending).
- Exception (`rdy`=1), any state: state ← IDLE, counters ← 0, pulses ← 0.
  - No result is delivered for the aborted fetch.
  - Exception beats a coincident request; that request is dropped.
- `rdy`=0: all registers hold, pulses are held too, and `mem_a` = `base + rcv_cnt`.
  - On resume, `issue_cnt` is reloaded from `rcv_cnt`, so any byte in flight during the stall is re-read.
- Reset (with or without `rdy`, in any state):
  - state IDLE, counters 0, buffer 0.
  - `instr_to_ic`=0, `is_instr_to_ic`=0, `is_commit_to_ic`=0.
  - `mem_a`=0, `mem_wr`=0.
  - A reset mid-fetch discards the fetch.

## Timing

- Request sampled at edge E0.
  - `mem_a` = A, A+1, A+2, A+3 in cycles C1..C4.
  - Bytes are captured at E2..E5.
  - Pulses are high in C6 only.
- Latency from request edge to pulse: 6 cycles, when there is no stall.
- Each `rdy`=0 cycle adds one cycle. A stall during FETCH costs one extra cycle for the re-read.
- Back-to-back: a request sampled at E6 (during the pulse cycle) is accepted. Minimum spacing between pulses is 6 cycles.
- An exception sampled at the completion edge E5 suppresses the C6 pulse.
- `mem_a` is combinational from `base` and the counters; `mem_a` = `base` in IDLE.

## Structure

- `PcLength`, `DataLength`, `True`, `False` and `Zero` come from shared `parameters.v`.
- State codes are local `localparam`s.
- No sub-module; byte assembly and the counters live in one always block plus one continuous assign for `mem_a`.

## Test plan

- Reset, then request A=0x0000_1000 with RAM bytes 0x13,0x05,0x10,0x00:
  - `mem_a` sequence 0x1000..0x1003 in C1..C4.
  - `instr_to_ic`=0x0010_0513 with both pulses high in C6 only.
- Request A=0xFFFF_FFFE:
  - `mem_a` = FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
  - Instruction assembled correctly.
- Exception asserted in C3 of a fetch:
  - No pulse ever appears.
  - A new request at the next edge completes normally 6 cycles later.
- `rdy`=0 for cycles C3–C4:
  - Outputs and counters frozen; the byte at A+1 is re-read on resume.
  - Correct instruction; pulse in C9.
- Request coincident with exception: dropped, block stays IDLE.
- Second request sampled during a pulse cycle: accepted; its pulse appears 6 cycles later.
- `rst` asserted mid-fetch:
  - Next cycle all outputs are 0 and state is IDLE.
  - No stale pulse.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants, state type and byte-packing helper
// for the instruction fetch controller.
package fc_pkg;

  localparam int PcLen   = 31;
  localparam int DataLen = 31;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [2:0] Zero    = 3'd0;
  localparam logic [2:0] NBytes  = 3'd4;
  localparam logic [2:0] LastIdx = 3'd3;

  typedef enum logic {
    Idle,
    Fetch
  } state_t;

  function automatic logic [31:0] pack_le(
    input logic [7:0] b3,
    input logic [7:0] b2,
    input logic [7:0] b1,
    input logic [7:0] b0
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/fc.sv
// Instruction fetch controller: reads four RAM bytes for an
// icache miss and returns them as one little-endian word.
module fc
  import fc_pkg::*;
#(
  parameter int PcLength   = PcLen,
  parameter int DataLength = DataLen
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [PcLength:0]   addr_from_ic,
  input  logic                is_empty_from_ic,
  input  logic                is_exception_from_rob,
  input  logic [7:0]          mem_din,
  output logic [PcLength:0]   mem_a,
  output logic                mem_wr,
  output logic [DataLength:0] instr_to_ic,
  output logic                is_instr_to_ic,
  output logic                is_commit_to_ic
);

  state_t            state;
  state_t            state_nx;
  logic [PcLength:0] base;
  logic [2:0]        issue_cnt;
  logic [2:0]        rcv_cnt;
  logic [2:0]        issue_eff;
  logic              stall;
  logic [7:0]        byte_buf [4];
  logic              pulse;
  logic              req;
  logic              capture;
  logic              done;

  // After a stall the in-flight byte is lost, so issue restarts at rcv_cnt.
  always_comb begin
    issue_eff = stall ? rcv_cnt : issue_cnt;
    req       = !is_empty_from_ic;
    capture   = (state == Fetch) && (issue_eff != rcv_cnt);
    done      = capture && (rcv_cnt == LastIdx);
    state_nx  = state;
    if (is_exception_from_rob) begin
      state_nx = Idle;
    end else begin
      unique case (state)
        Idle:  if (req)  state_nx = Fetch;
        Fetch: if (done) state_nx = Idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Idle;
    end else if (rdy) begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base        <= '0;
      issue_cnt   <= Zero;
      rcv_cnt     <= Zero;
      stall       <= False;
      instr_to_ic <= '0;
      pulse       <= False;
      for (int i = 0; i < 4; i++) begin
        byte_buf[i] <= '0;
      end
    end else if (!rdy) begin
      stall <= True;
    end else begin
      stall <= False;
      pulse <= False;
      if (is_exception_from_rob) begin
        issue_cnt <= Zero;
        rcv_cnt   <= Zero;
      end else if (state == Idle) begin
        if (req) begin
          base      <= addr_from_ic;
          issue_cnt <= Zero;
          rcv_cnt   <= Zero;
        end
      end else if (done) begin
        byte_buf[3] <= mem_din;
        instr_to_ic <= (DataLength + 1)'(pack_le(
          mem_din, byte_buf[2], byte_buf[1], byte_buf[0]));
        pulse       <= True;
        issue_cnt   <= Zero;
        rcv_cnt     <= Zero;
      end else begin
        if (capture) begin
          byte_buf[rcv_cnt[1:0]] <= mem_din;
          rcv_cnt                <= rcv_cnt + 3'd1;
        end
        if (issue_eff != NBytes) begin
          issue_cnt <= issue_eff + 3'd1;
        end else begin
          issue_cnt <= issue_eff;
        end
      end
    end
  end

  assign mem_a = (state == Idle) ? base :
    base + (PcLength + 1)'(rdy ? issue_eff : rcv_cnt);

  assign mem_wr          = False;
  assign is_instr_to_ic  = pulse;
  assign is_commit_to_ic = pulse;

endmodule
